// File: rtl/switching_decision_stage_pkg.sv
// Shared constants and types for the switching decision stage.
package switching_decision_stage_pkg;
   localparam int unsigned PIXEL_W     = 8;
   localparam int unsigned COUNT_W     = 16;
   localparam logic [PIXEL_W-1:0] DEFAULT_THR = 8'd20;
   localparam logic [PIXEL_W-1:0] PIXEL_MAX   = {PIXEL_W{1'b1}};

   typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

// File: rtl/switching_decision_stage_noise_frame_counter.sv
// Per-frame saturating noisy-pixel counter with frame-end report pulse.
module noise_frame_counter #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc_i,
   input  logic               frame_end_i,
   output logic [COUNT_W-1:0] count_o,
   output logic               count_valid_o
);
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [COUNT_W-1:0] count_q;
   logic               cv_q;

   // Saturating increment including the current pixel.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
   end

   // Frame end reports the total (current pixel included) and restarts from zero,
   // so the frame's last pixel never leaks into the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         count_q <= '0;
         cv_q    <= 1'b0;
      end else if (frame_end_i) begin
         cnt_q   <= '0;
         count_q <= cnt_d;
         cv_q    <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         cv_q    <= 1'b0;
      end
   end

   assign count_o       = count_q;
   assign count_valid_o = cv_q;
endmodule

// File: rtl/switching_decision_stage.sv
// Threshold compare and MV/CV switch; classifies each pixel noisy or clean.
module switching_decision_stage
   import switching_decision_stage_pkg::*;
#(
   parameter int unsigned      PIXEL_W     = switching_decision_stage_pkg::PIXEL_W,
   parameter logic [PIXEL_W-1:0] DEFAULT_THR = switching_decision_stage_pkg::DEFAULT_THR,
   parameter int unsigned      COUNT_W     = switching_decision_stage_pkg::COUNT_W,
   parameter bit               EXTREME_EN  = 1'b1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [PIXEL_W-1:0] CV,
   input  logic [PIXEL_W-1:0] MV,
   input  logic [PIXEL_W-1:0] AD,
   input  logic               In_Valid,
   input  logic               Bypass,
   input  logic               Thr_Load,
   input  logic [PIXEL_W-1:0] Thr_In,
   input  logic               Frame_End,
   output logic               Out_Valid,
   output logic [PIXEL_W-1:0] Out_Pixel,
   output logic               Noisy_Flag,
   output logic [COUNT_W-1:0] Noisy_Count,
   output logic               Count_Valid
);
   localparam logic [PIXEL_W-1:0] PMAX = {PIXEL_W{1'b1}};

   logic [PIXEL_W-1:0] cv_a_q;
   logic [PIXEL_W-1:0] thr_q;
   logic               out_valid_q;
   logic [PIXEL_W-1:0] out_pixel_q, out_pixel_d;
   logic               noisy_flag_q;
   logic               extreme;
   logic               noisy;

   // CV_A lines up with AD: the upstream stage registered CV once before subtracting.
   always_ff @(posedge Clk) begin
      if (Reset) cv_a_q <= '0;
      else       cv_a_q <= CV;
   end

   // Threshold register; a load only affects pixels from the next cycle on.
   always_ff @(posedge Clk) begin
      if (Reset)         thr_q <= DEFAULT_THR;
      else if (Thr_Load) thr_q <= Thr_In;
   end

   // Strict unsigned compare plus optional salt-and-pepper detection.
   always_comb begin
      extreme     = EXTREME_EN && ((cv_a_q == '0) || (cv_a_q == PMAX));
      noisy       = !Bypass && ((AD > thr_q) || extreme);
      out_pixel_d = noisy ? MV : cv_a_q;
   end

   // Output register; pixel and flag hold when no pixel arrives.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid_q  <= 1'b0;
         out_pixel_q  <= '0;
         noisy_flag_q <= 1'b0;
      end else begin
         out_valid_q <= In_Valid;
         if (In_Valid) begin
            out_pixel_q  <= out_pixel_d;
            noisy_flag_q <= noisy;
         end
      end
   end

   noise_frame_counter #(.COUNT_W(COUNT_W)) u_cnt (
      .clk          (Clk),
      .reset        (Reset),
      .inc_i        (In_Valid & noisy),
      .frame_end_i  (Frame_End),
      .count_o      (Noisy_Count),
      .count_valid_o(Count_Valid)
   );

   assign Out_Valid  = out_valid_q;
   assign Out_Pixel  = out_pixel_q;
   assign Noisy_Flag = noisy_flag_q;
endmodule

// File: doc/switching_decision_stage.md
Name: switching_decision_stage

Overview:
- Sits directly downstream of the threshold-value stage, which produces AD = |MV - CV| with CV registered one cycle internally.
- Compares AD against a programmable threshold and classifies each pixel as noisy or clean.
- Emits the switched pixel: MV if noisy, aligned CV if clean. Keeps a per-frame saturating count of noisy pixels.

Parameters:
- PIXEL_W, 8, pixel/AD/MV/CV width.
- DEFAULT_THR, 8'd20, threshold value after reset.
- COUNT_W, 16, width of the per-frame noisy-pixel counter.
- EXTREME_EN, 1, when 1 an aligned CV of 0 or 2^PIXEL_W-1 is also classified noisy (salt-and-pepper).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- CV  in  PIXEL_W  centre pixel; the same signal fed to the threshold-value stage.
- MV  in  PIXEL_W  median value, same cycle as AD.
- AD  in  PIXEL_W  absolute difference from the threshold-value stage.
- In_Valid  in  1  qualifies MV/AD in this cycle.
- Bypass  in  1  forces pass-through of the aligned CV.
- Thr_Load  in  1  loads Thr_In into the threshold register.
- Thr_In  in  PIXEL_W  new threshold.
- Frame_End  in  1  one-cycle pulse marking the last pixel slot of a frame.
- Out_Valid  out  1  Out_Pixel/Noisy_Flag valid.
- Out_Pixel  out  PIXEL_W  switched pixel.
- Noisy_Flag  out  1  pixel classified noisy.
- Noisy_Count  out  COUNT_W  noisy count of the last completed frame.
- Count_Valid  out  1  one-cycle pulse when Noisy_Count updates.

Behaviour:
- Clocking: one clock, Clk. Reset is synchronous and active-high; all registers clear at the Clk edge where Reset=1.
- Reset values:
  - Out_Valid=0, Out_Pixel=0, Noisy_Flag=0, Noisy_Count=0, Count_Valid=0.
  - Threshold register = DEFAULT_THR; internal counter = 0; CV alignment register = 0.
- CV alignment: an internal register samples CV every cycle, independent of In_Valid (CV_A). CV_A is the value that AD was computed from.
- Classification, combinational on the In_Valid cycle:
  - noisy = !Bypass & ((AD > Thr) | (EXTREME_EN & (CV_A==0 | CV_A==all-ones))).
  - The comparison is strict, unsigned, PIXEL_W bits. AD == Thr is clean.
- Output register, latency 1:
  - On an edge with In_Valid=1: Out_Valid<=1, Noisy_Flag<=noisy, Out_Pixel<= noisy ? MV : CV_A.
  - On an edge with In_Valid=0: Out_Valid<=0. Out_Pixel and Noisy_Flag hold their previous values.
- Threshold register:
  - Thr_Load=1 loads Thr_In at the edge.
  - If Thr_Load and In_Valid occur in the same cycle, that pixel uses the OLD threshold. The new value applies from the next cycle.
- Noisy counter:
  - Increments on an edge with In_Valid & noisy.
  - Saturates at 2^COUNT_W-1 and never wraps.
- Frame end: on an edge with Frame_End=1:
  - Noisy_Count <= counter + (In_Valid & noisy), saturated.
  - Count_Valid <= 1 for exactly one cycle, coincident with the Out_Valid of the last pixel.
  - Internal counter <= 0. The current pixel is never carried into the next frame.
- Frame_End with In_Valid=0 still reports. Back-to-back Frame_End pulses report 0 on the second.
- Bypass=1: Out_Pixel=CV_A, Noisy_Flag=0, no count increment. Bypass may change on any cycle and takes effect on that cycle's pixel.
- Reset mid-frame: the partial count is discarded, no Count_Valid pulse occurs, and the threshold reverts to DEFAULT_THR.
- Optional FSM states (IDLE/ACTIVE) are not required. Behaviour is fully defined by the registers above.

Decomposition:
- Shared package: PIXEL_W, DEFAULT_THR, COUNT_W constants; PIXEL_MAX (all-ones) constant; pixel_t typedef.
- One natural sub-module: noise_frame_counter. It holds the saturating counter, Frame_End latch and clear, and the Count_Valid pulse.
- The compare/select and alignment logic stay in the top module.

Test Plan:
- Reset, default thr 20: cycle n CV=100; cycle n+1 In_Valid=1, MV=130, AD=30 -> next cycle Out_Valid=1, Out_Pixel=130, Noisy_Flag=1.
- Boundary: CV=100 then MV=120, AD=20, thr 20 -> Out_Pixel=100, Noisy_Flag=0. With AD=21 -> Out_Pixel=120, Noisy_Flag=1.
- Threshold load collision: Thr_Load=1, Thr_In=50 in the same cycle as AD=30, In_Valid=1 -> noisy (old thr 20). Next pixel AD=30 -> clean.
- Extreme check (EXTREME_EN=1): CV=255 then MV=250, AD=5 -> noisy, Out_Pixel=250. Bypass=1 with the same data -> Out_Pixel=255, flag 0.
- Frame counting: 10 pixels with 4 noisy, the last one noisy with Frame_End -> Count_Valid pulse, Noisy_Count=4. A following Frame_End alone -> Noisy_Count=0.
- Saturation/reset: COUNT_W=4, 20 noisy pixels then Frame_End -> Noisy_Count=15. Reset asserted mid-frame -> no Count_Valid pulse, all outputs 0, thr=20.
